playback_scheduler: RTL and testbench

//  Sequences pattern playback. Converts the user BPM into exact-average step ticks, walks the step index over a pattern of NUM_STEPS steps, and counts loops.

---
 rtl/playback_scheduler_if.sv | 45 ++++
 rtl/playback_scheduler.sv | 112 +++++++++++
 tb/tb_playback_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/playback_scheduler_if.sv
// playback_scheduler_if
//   Groups the control and status signals between the keyboard front end
//   (master) and the playback scheduler (slave). Clock and reset are not part
//   of the bundle.
//
//   Control (master -> slave):
//     Start      one-cycle request to begin playback
//     Stop       level or pulse; aborts playback
//     BPM        tempo in beats per minute, 0 freezes the playhead
//     Loops      passes to play, 0 = forever
//   Status (slave -> master):
//     play_en    high while playing
//     step_tick  one-cycle pulse: play the step shown on Step
//     Step       current step index
//     loop_count completed passes in the current playback
//     Done       one-cycle pulse on natural completion
//     dbg_state  scheduler FSM state (1 = PLAY)
//
//   Handshake: there is no ready signal. Start is a request that counts only
//   on an edge where the scheduler is idle, Stop is low and BPM is non-zero;
//   otherwise it is dropped, never queued. step_tick and Done are single-cycle
//   qualifiers on the registered Step / loop_count values and are never high
//   together.
interface playback_scheduler_if;
    logic       Start;
    logic       Stop;
    logic [9:0] BPM;
    logic [6:0] Loops;
    logic       play_en;
    logic       step_tick;
    logic [3:0] Step;
    logic [6:0] loop_count;
    logic       Done;
    logic       dbg_state;

    modport master (
        output Start, Stop, BPM, Loops,
        input  play_en, step_tick, Step, loop_count, Done, dbg_state
    );

    modport slave (
        input  Start, Stop, BPM, Loops,
        output play_en, step_tick, Step, loop_count, Done, dbg_state
    );
endinterface

// File: rtl/playback_scheduler.sv
// playback_scheduler
//   Sequences pattern playback. A phase accumulator adds BPM*STEP_DIV every
//   clock and advances the step each time it crosses CLK_HZ*60, which gives an
//   exact long-term average step rate with no division. The step index walks
//   0..NUM_STEPS-1, passes are counted, and playback ends after Loops passes
//   (Loops==0 plays forever) or when Stop is asserted.
//
//   Ports:
//     CLOCK_50  system clock
//     Reset     asynchronous, active-high reset
//     bus       playback_scheduler_if.slave (control in, status out)
//
//   All status outputs are registered.
module playback_scheduler #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int NUM_STEPS = 16,
    parameter int STEP_DIV  = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    playback_scheduler_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [32:0] THRESH    = 33'(CLK_HZ) * 33'd60;
    localparam logic [32:0] INC_SCALE = 33'(STEP_DIV);
    localparam logic [3:0]  LAST_STEP = 4'(NUM_STEPS - 1);

    state_t      state;
    logic [32:0] acc;
    logic [6:0]  loops_lat;

    logic [32:0] acc_next;
    logic        overflow;
    logic        last_step;
    logic [6:0]  count_inc;
    logic        finish;

    // BPM is used live: a tempo change alters the increment on the very next
    // edge without disturbing the phase already accumulated.
    assign acc_next  = acc + 33'(bus.BPM) * INC_SCALE;
    assign overflow  = (acc_next >= THRESH);
    assign last_step = (bus.Step == LAST_STEP);

    // Saturates so infinite playback cannot wrap the pass counter to 0.
    assign count_inc = (bus.loop_count == 7'd127) ? 7'd127 : bus.loop_count + 7'd1;
    assign finish    = (loops_lat != 7'd0) && (count_inc == loops_lat);

    assign bus.dbg_state = state;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            acc            <= '0;
            loops_lat      <= '0;
            bus.play_en    <= 1'b0;
            bus.step_tick  <= 1'b0;
            bus.Step       <= '0;
            bus.loop_count <= '0;
            bus.Done       <= 1'b0;
        end else begin
            bus.step_tick <= 1'b0;
            bus.Done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start && !bus.Stop && (bus.BPM != 10'd0)) begin
                        // Step 0 is announced on entry, one cycle after Start.
                        state          <= PLAY;
                        acc            <= '0;
                        loops_lat      <= bus.Loops;
                        bus.play_en    <= 1'b1;
                        bus.step_tick  <= 1'b1;
                        bus.Step       <= '0;
                        bus.loop_count <= '0;
                    end
                end
                PLAY: begin
                    if (bus.Stop) begin
                        // Stop wins over a coincident step advance or wrap.
                        state       <= IDLE;
                        acc         <= '0;
                        bus.play_en <= 1'b0;
                        bus.Step    <= '0;
                    end else if (overflow) begin
                        acc <= acc_next - THRESH;
                        if (!last_step) begin
                            bus.Step      <= bus.Step + 4'd1;
                            bus.step_tick <= 1'b1;
                        end else begin
                            bus.loop_count <= count_inc;
                            bus.Step       <= '0;
                            if (finish) begin
                                state       <= IDLE;
                                bus.play_en <= 1'b0;
                                bus.Done    <= 1'b1;
                            end else begin
                                bus.step_tick <= 1'b1;
                            end
                        end
                    end else begin
                        acc <= acc_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playback_scheduler.sv
// tb_playback_scheduler
//   Bench for playback_scheduler with CLK_HZ=100, NUM_STEPS=4, STEP_DIV=4,
//   so one step is due each time the summed BPM*4 crosses a multiple of 6000.
//   Inputs are driven 1 time unit after the rising edge, outputs are sampled
//   at the same point, so each sample shows the result of the last edge.
module tb_playback_scheduler;

    localparam int TH = 6000;
    localparam int NS = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    playback_scheduler_if bus();

    playback_scheduler #(
        .CLK_HZ    (100),
        .NUM_STEPS (4),
        .STEP_DIV  (4)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [13:0] pack(input logic p, input logic t, input logic [3:0] s,
                                         input logic [6:0] lc, input logic d);
        return {p, t, s, lc, d};
    endfunction

    function automatic logic [13:0] outs();
        return {bus.play_en, bus.step_tick, bus.Step, bus.loop_count, bus.Done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic st, input logic [9:0] b, input logic [6:0] l);
        bus.Start = s;
        bus.Stop  = st;
        bus.BPM   = b;
        bus.Loops = l;
    endtask

    // Waits for the next step_tick, at most 'bound' cycles; returns cycles taken
    // (bound+1 if it never came, which the caller's check then reports).
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.step_tick && n <= bound);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic       stop;
        logic [9:0] bpm;
        logic [6:0] loops;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[17];

    // ---------------- reference model ----------------
    // Playback position is the whole number of thresholds crossed by the total
    // phase since Start; step and pass follow by division.
    bit     m_play;
    longint m_total;
    int     m_lat;
    int     e_step;
    int     e_lc;
    bit     e_tick;
    bit     e_done;

    task automatic model_edge(input bit s, input bit st, input int bpm, input int loops);
        longint old_n;
        longint new_n;
        int     passes;
        e_tick = 0;
        e_done = 0;
        if (!m_play) begin
            if (s && !st && bpm != 0) begin
                m_play  = 1;
                m_total = 0;
                m_lat   = loops;
                e_tick  = 1;
                e_step  = 0;
                e_lc    = 0;
            end
        end else if (st) begin
            m_play = 0;
            e_step = 0;
        end else begin
            old_n   = m_total / TH;
            m_total = m_total + longint'(bpm * 4);
            new_n   = m_total / TH;
            if (new_n > old_n) begin
                passes = int'(new_n / NS);
                e_step = int'(new_n % NS);
                e_lc   = (passes > 127) ? 127 : passes;
                if (e_step == 0 && m_lat != 0 && passes == m_lat) begin
                    m_play = 0;
                    e_done = 1;
                end else begin
                    e_tick = 1;
                end
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int k;
        int done_k;
        bit bad;
        bit r_s;
        bit r_st;
        int r_bpm;
        int r_loops;

        n_cmp  = 0;
        n_fail = 0;

        // 1. reset with Start held
        drive(1'b1, 1'b0, 10'd300, 7'd0);
        rst = 1'b1;
        repeat (3) cyc();
        check("reset_outputs", 32'(outs()), 32'(pack(0, 0, 0, 0, 0)));
        drive(1'b0, 1'b0, 10'd300, 7'd0);
        rst = 1'b0;
        repeat (3) cyc();
        check("post_reset_idle", 32'(outs()), 32'(pack(0, 0, 0, 0, 0)));

        // Table: ignored starts, a 1-pass play at BPM=600, then start/stop.
        vecs[0]  = '{1, 0, 10'd0,    7'd0, pack(0, 0, 0, 0, 0)};
        vecs[1]  = '{1, 1, 10'd300,  7'd0, pack(0, 0, 0, 0, 0)};
        vecs[2]  = '{0, 0, 10'd300,  7'd0, pack(0, 0, 0, 0, 0)};
        vecs[3]  = '{1, 0, 10'd600,  7'd1, pack(1, 1, 0, 0, 0)};
        vecs[4]  = '{0, 0, 10'd600,  7'd1, pack(1, 0, 0, 0, 0)};
        vecs[5]  = '{0, 0, 10'd600,  7'd1, pack(1, 0, 0, 0, 0)};
        vecs[6]  = '{0, 0, 10'd600,  7'd1, pack(1, 1, 1, 0, 0)};
        vecs[7]  = '{0, 0, 10'd600,  7'd1, pack(1, 0, 1, 0, 0)};
        vecs[8]  = '{0, 0, 10'd600,  7'd1, pack(1, 1, 2, 0, 0)};
        vecs[9]  = '{0, 0, 10'd600,  7'd1, pack(1, 0, 2, 0, 0)};
        vecs[10] = '{0, 0, 10'd600,  7'd1, pack(1, 0, 2, 0, 0)};
        vecs[11] = '{0, 0, 10'd600,  7'd1, pack(1, 1, 3, 0, 0)};
        vecs[12] = '{0, 0, 10'd600,  7'd1, pack(1, 0, 3, 0, 0)};
        vecs[13] = '{0, 0, 10'd600,  7'd1, pack(0, 0, 0, 1, 1)};
        vecs[14] = '{0, 0, 10'd600,  7'd1, pack(0, 0, 0, 1, 0)};
        vecs[15] = '{1, 0, 10'd1023, 7'd0, pack(1, 1, 0, 0, 0)};
        vecs[16] = '{0, 1, 10'd1023, 7'd0, pack(0, 0, 0, 0, 0)};
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].bpm, vecs[i].loops);
            cyc();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        drive(1'b0, 1'b0, 10'd300, 7'd0);
        cyc();

        // 2. BPM=300, Loops=2: ticks every 5 cycles, Done at +41
        drive(1'b1, 1'b0, 10'd300, 7'd2);
        cyc();
        bus.Start = 1'b0;
        for (k = 1; k <= 45; k++) begin
            check($sformatf("t2_tick_k%0d", k), 32'(bus.step_tick),
                  32'((k <= 36) && ((k - 1) % 5 == 0)));
            check($sformatf("t2_done_k%0d", k), 32'(bus.Done), 32'(k == 41));
            if ((k <= 36) && ((k - 1) % 5 == 0))
                check($sformatf("t2_step_k%0d", k), 32'(bus.Step), 32'(((k - 1) / 5) % 4));
            if (k == 41) begin
                check("t2_play_en_end", 32'(bus.play_en), 32'd0);
                check("t2_loop_count_end", 32'(bus.loop_count), 32'd2);
            end
            cyc();
        end

        // 3. BPM=600, Loops=0: intervals 3,2,3,2,...
        drive(1'b1, 1'b0, 10'd600, 7'd0);
        cyc();
        bus.Start = 1'b0;
        check("t3_first_tick", 32'(bus.step_tick), 32'd1);
        for (int t = 2; t <= 13; t++) begin
            wait_tick(10, n);
            check($sformatf("t3_interval_%0d", t), 32'(n), 32'((t % 2 == 0) ? 3 : 2));
        end
        check("t3_loop_count", 32'(bus.loop_count), 32'd3);
        check("t3_play_en", 32'(bus.play_en), 32'd1);
        bus.Stop = 1'b1;
        cyc();
        bus.Stop = 1'b0;

        // 4. Stop coincident with a due tick
        drive(1'b1, 1'b0, 10'd300, 7'd0);
        cyc();
        bus.Start = 1'b0;
        repeat (4) cyc();
        check("t4_no_early_tick", 32'(bus.step_tick), 32'd0);
        bus.Stop = 1'b1;
        cyc();
        bus.Stop = 1'b0;
        check("t4_stop_outputs", 32'({bus.play_en, bus.step_tick, bus.Step, bus.Done}), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.Done || bus.step_tick || bus.play_en) bad = 1;
        end
        check("t4_quiet_after_stop", 32'(bad), 32'd0);

        // 5. BPM freeze and resume
        drive(1'b1, 1'b0, 10'd300, 7'd0);
        cyc();
        bus.Start = 1'b0;
        repeat (5) cyc();
        check("t5_tick_step1", 32'({bus.step_tick, bus.Step}), 32'({1'b1, 4'd1}));
        bus.BPM = 10'd0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.step_tick || bus.Step != 4'd1 || !bus.play_en) bad = 1;
        end
        check("t5_frozen", 32'(bad), 32'd0);
        bus.BPM = 10'd300;
        wait_tick(10, n);
        check("t5_resume_interval", 32'(n), 32'd5);
        check("t5_resume_step", 32'(bus.Step), 32'd2);
        bus.Stop = 1'b1;
        cyc();
        bus.Stop = 1'b0;

        // 6. Start pulses and Loops change during PLAY are ignored
        drive(1'b1, 1'b0, 10'd300, 7'd2);
        cyc();
        bus.Start = 1'b0;
        done_k = 0;
        for (k = 2; k <= 60 && done_k == 0; k++) begin
            if (k == 10) bus.Loops = 7'd5;
            bus.Start = (k % 7 == 0);
            cyc();
            if (bus.Done) done_k = k;
        end
        bus.Start = 1'b0;
        check("t6_done_cycle", 32'(done_k), 32'd41);
        check("t6_loop_count", 32'(bus.loop_count), 32'd2);
        cyc();

        // Reset mid-playback
        drive(1'b1, 1'b0, 10'd1023, 7'd0);
        cyc();
        bus.Start = 1'b0;
        repeat (3) cyc();
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'(pack(0, 0, 0, 0, 0)));
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        check("after_reset_idle", 32'(outs()), 32'(pack(0, 0, 0, 0, 0)));

        // Randomised run against the reference model
        m_play = 0; m_total = 0; m_lat = 0; e_step = 0; e_lc = 0; e_tick = 0; e_done = 0;
        r_bpm = 300;
        r_loops = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0)
                r_bpm = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 1023));
            if ($urandom_range(0, 29) == 0) r_loops = int'($urandom_range(0, 3));
            r_s  = ($urandom_range(0, 7) == 0);
            r_st = ($urandom_range(0, 79) == 0);
            drive(r_s, r_st, 10'(r_bpm), 7'(r_loops));
            model_edge(r_s, r_st, r_bpm, r_loops);
            cyc();
            check($sformatf("rand_c%0d", i), 32'(outs()),
                  32'(pack(m_play, e_tick, 4'(e_step), 7'(e_lc), e_done)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
